multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Main control sequencer for the multicycle MIPS datapath. It shares one ALU and one unified memory across the fetch, decode, execute and writeback steps of each instruction.
- Decodes Opcode and steps through a Moore state machine, driving datapath mux selects, write strobes and the 2-bit ALUOp that feeds the ALU decoder.
- Supports a memory-ready handshake so that memory accesses can stall.

Parameters:
- STATE_W, 4, width of the state register (12 states used).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- Opcode  input  6  Instr[31:26] from the instruction register
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory has completed the current access this cycle
- ALUOp  output  2  to ALU decoder: 00 add, 01 sub, 10 use Funct
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- PCSrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load enable
- RegDst  output  1  0 = rt, 1 = rd
- MemtoReg  output  1  0 = ALUOut, 1 = Data
- RegWrite  output  1  register file write enable
- PCEn  output  1  PC load enable = PCWrite | (Branch & Zero)
- InstrDone  output  1  one-cycle pulse on the last cycle of each instruction
- State  output  STATE_W  current state, for debug and visibility

Behaviour:
- Reset: rst_n low asynchronously forces State to FETCH (0).
- While rst_n is low, all strobes are forced to 0: MemWrite, IRWrite, RegWrite, PCEn, InstrDone. The mux selects take their FETCH values.
- Outputs are decoded from State only, except for two exceptions:
  - the MemReady gating in FETCH and MEMWRITE;
  - PCEn, which depends on Zero.
- Unlisted outputs are 0 in every state.
- State encodings and outputs:
  - FETCH (0): IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=MemReady, PCWrite=MemReady. Stay in FETCH while !MemReady, else go to DECODE.
  - DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precompute branch target). Next state by Opcode:
    - lw 100011 or sw 101011 -> MEMADR
    - R-type 000000 -> EXECUTE
    - beq 000100 -> BRANCH
    - addi 001000 -> ADDIEXEC
    - j 000010 -> JUMP
    - any other opcode -> FETCH, with InstrDone=1 (treated as a NOP)
  - MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: lw -> MEMREAD, sw -> MEMWRITE. Opcode is sampled from the IR, which is stable.
  - MEMREAD (3): IorD=1. Stay while !MemReady, else go to MEMWB.
  - MEMWB (4): RegDst=0, MemtoReg=1, RegWrite=1, InstrDone=1. Next: FETCH.
  - MEMWRITE (5): IorD=1, MemWrite=1 held until MemReady, InstrDone=MemReady. Stay while !MemReady, else go to FETCH.
  - EXECUTE (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - ALUWB (7): RegDst=1, MemtoReg=0, RegWrite=1, InstrDone=1. Next: FETCH.
  - BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1, InstrDone=1. Next: FETCH.
  - ADDIEXEC (9): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDIWB.
  - ADDIWB (10): RegDst=0, MemtoReg=0, RegWrite=1, InstrDone=1. Next: FETCH.
  - JUMP (11): PCSrc=10, PCWrite=1, InstrDone=1. Next: FETCH.
  - Encodings 12–15 are illegal and return to FETCH on the next edge with all strobes 0.
- Latency with MemReady tied high, in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2.
- Each cycle with MemReady low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Strobes do not repeat during a stall.
- Branch: PCEn is asserted in BRANCH only when Zero=1 in that same cycle.
- Reset asserted mid-instruction: the in-flight instruction is abandoned with no further RegWrite or MemWrite. Execution resumes in FETCH on the first edge after rst_n rises.
- Invariants:
  - at most one of RegWrite/MemWrite/IRWrite is high in any cycle;
  - InstrDone is high for exactly one cycle per instruction.

Test Plan:
- Reset: hold rst_n=0 mid-EXECUTE, then release -> State=0, all strobes 0 during reset, first post-reset cycle has IRWrite=1 and PCEn=1 (MemReady=1).
- R-type: Opcode=000000, MemReady=1 -> states 0,1,6,7,0. ALUOp=10 in EXECUTE. RegWrite=1 and RegDst=1 only in ALUWB. InstrDone pulses at cycle 4.
- lw with stalls: Opcode=100011, MemReady low for 2 cycles in FETCH and 3 cycles in MEMREAD -> total 10 cycles. IRWrite pulses once. RegWrite with MemtoReg=1 happens once.
- sw: Opcode=101011 -> MemWrite=1 with IorD=1 only in state 5, InstrDone coincident with MemReady. RegWrite never asserted.
- beq: Zero=1 -> PCEn=1 with PCSrc=01 in BRANCH. Repeat with Zero=0 -> PCEn=0. Both return to FETCH after 3 cycles.
- j and illegal opcode: Opcode=000010 -> PCSrc=10, PCEn=1 in JUMP. Opcode=111111 -> DECODE to FETCH with no strobes and InstrDone=1.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_fsm
// Purpose  : Main control sequencer for a multicycle MIPS datapath. It steps
//            each instruction through fetch, decode, execute and writeback.
//            It drives the datapath mux selects, the write strobes and the
//            2-bit ALUOp. A memory-ready handshake lets memory accesses stall.
// Ports    : clk, rst_n (async, active-low)
//            Opcode[5:0], Zero, MemReady          - inputs
//            ALUOp[1:0], ALUSrcA, ALUSrcB[1:0],
//            PCSrc[1:0], IorD, RegDst, MemtoReg    - mux selects
//            MemWrite, IRWrite, RegWrite, PCEn     - write strobes
//            InstrDone                             - last cycle of an instr
//            State[STATE_W-1:0]                    - current state (debug)
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         Opcode,
  input  logic               Zero,
  input  logic               MemReady,
  output logic [1:0]         ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               PCEn,
  output logic               InstrDone,
  output logic [STATE_W-1:0] State
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEMADR   = STATE_W'(2),
    S_MEMREAD  = STATE_W'(3),
    S_MEMWB    = STATE_W'(4),
    S_MEMWRITE = STATE_W'(5),
    S_EXECUTE  = STATE_W'(6),
    S_ALUWB    = STATE_W'(7),
    S_BRANCH   = STATE_W'(8),
    S_ADDIEXEC = STATE_W'(9),
    S_ADDIWB   = STATE_W'(10),
    S_JUMP     = STATE_W'(11)
  } state_t;

  state_t r_state;

  // Single state register; any unused encoding falls back to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:    r_state <= MemReady ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (Opcode)
            c_OP_LW, c_OP_SW: r_state <= S_MEMADR;
            c_OP_RTYPE:       r_state <= S_EXECUTE;
            c_OP_BEQ:         r_state <= S_BRANCH;
            c_OP_ADDI:        r_state <= S_ADDIEXEC;
            c_OP_J:           r_state <= S_JUMP;
            default:          r_state <= S_FETCH;
          endcase
        end
        // Opcode comes from the IR, which holds steady for the whole instr.
        S_MEMADR:   r_state <= (Opcode == c_OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  r_state <= MemReady ? S_MEMWB : S_MEMREAD;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWRITE: r_state <= MemReady ? S_FETCH : S_MEMWRITE;
        S_EXECUTE:  r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_BRANCH:   r_state <= S_FETCH;
        S_ADDIEXEC: r_state <= S_ADDIWB;
        S_ADDIWB:   r_state <= S_FETCH;
        S_JUMP:     r_state <= S_FETCH;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  logic w_op_known;
  logic w_pcwrite;
  logic w_branch;
  logic w_memwrite;
  logic w_irwrite;
  logic w_regwrite;
  logic w_done;

  always_comb begin
    w_op_known = (Opcode == c_OP_LW)   || (Opcode == c_OP_SW)   ||
                 (Opcode == c_OP_RTYPE) || (Opcode == c_OP_BEQ) ||
                 (Opcode == c_OP_ADDI) || (Opcode == c_OP_J);
  end

  // Moore decode of the current state; MemReady only gates the FETCH and
  // MEMWRITE strobes so a stalled access never fires a second time.
  always_comb begin
    ALUOp      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b01;
        w_irwrite = MemReady;
        w_pcwrite = MemReady;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        w_done  = ~w_op_known;  // unknown opcode retires here as a NOP
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMREAD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_MEMWRITE: begin
        IorD       = 1'b1;
        w_memwrite = 1'b1;
        w_done     = MemReady;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSrc    = 2'b01;
        w_branch = 1'b1;
        w_done   = 1'b1;
      end
      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_JUMP: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
        w_done    = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are masked while reset is held; the state is already FETCH so
  // the mux selects naturally show their FETCH values.
  always_comb begin
    MemWrite  = rst_n & w_memwrite;
    IRWrite   = rst_n & w_irwrite;
    RegWrite  = rst_n & w_regwrite;
    InstrDone = rst_n & w_done;
    PCEn      = rst_n & (w_pcwrite | (w_branch & Zero));
    State     = r_state;
  end

endmodule
`default_nettype wire
